// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl: per-frame pacman position, facing and chomp sequencing with tile-aligned turns and tunnel wrap.
// Define PACMAN_TURN_BUFFER_EN to keep a turn request pending across frames until it can be applied.
module pacman_motion_ctrl #(
  parameter int START_X      = 304,
  parameter int START_Y      = 224,
  parameter int TILE         = 16,
  parameter int SPEED        = 1,
  parameter int CHOMP_FRAMES = 8,
  parameter int SCREEN_W     = 640
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start_of_frame,
  input  logic        key_valid,
  input  logic [1:0]  key_dir,
  input  logic [3:0]  wall_ahead,
  input  logic        freeze,
  input  logic        respawn,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y,
  output logic [1:0]  orientation,
  output logic        close_mouth,
  output logic        moving
);
  localparam int CW = $clog2(CHOMP_FRAMES + 1);
  localparam logic [10:0] SX = 11'(START_X);
  localparam logic [10:0] SY = 11'(START_Y);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] WRAP = 11'(SCREEN_W - TILE);
  localparam logic [10:0] TMASK = 11'(TILE - 1);
  localparam logic [CW-1:0] CLAST = CW'(CHOMP_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED} state_t;
  state_t state, nxt_state;
  logic pend_v, ep_v, aligned, rev, turn, step_ok;
  logic [1:0] pend_dir, ep_dir, new_or;
  logic [10:0] nx, ny;
  logic [CW-1:0] chomp;
  // a key arriving on the frame cycle overrides the buffered request
  assign ep_v = key_valid | pend_v;
  assign ep_dir = key_valid ? key_dir : pend_dir;
  assign aligned = ((top_left_x | top_left_y) & TMASK) == '0;
  assign rev = ep_v && state == MOVE && ep_dir == (orientation ^ 2'b01);
  assign turn = ep_v && aligned && !wall_ahead[ep_dir];
  assign new_or = (rev || turn) ? ep_dir : orientation;
  // IDLE/BLOCKED are always aligned, so a free turn there both starts and steps
  assign step_ok = (state == MOVE || turn) && !(aligned && wall_ahead[new_or]);
  assign nxt_state = step_ok ? MOVE : (state == MOVE ? BLOCKED : state);
  assign nx = new_or == 2'b10 ? (top_left_x == '0 ? WRAP : top_left_x - SP) :
              new_or == 2'b11 ? (top_left_x == WRAP ? '0 : top_left_x + SP) : top_left_x;
  assign ny = new_or == 2'b00 ? top_left_y - SP : new_or == 2'b01 ? top_left_y + SP : top_left_y;
  assign moving = state == MOVE;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      top_left_x <= SX;
      top_left_y <= SY;
      orientation <= 2'b11;
      close_mouth <= 1'b1;
      state <= IDLE;
      pend_v <= 1'b0;
      pend_dir <= 2'b00;
      chomp <= '0;
    end else if (respawn) begin
      top_left_x <= SX;
      top_left_y <= SY;
      orientation <= 2'b11;
      close_mouth <= 1'b1;
      state <= IDLE;
      pend_v <= 1'b0;
      pend_dir <= 2'b00;
      chomp <= '0;
    end else if (!freeze) begin
      if (start_of_frame) begin
        orientation <= new_or;
        state <= nxt_state;
        if (step_ok) begin
          top_left_x <= nx;
          top_left_y <= ny;
          chomp <= chomp == CLAST ? '0 : chomp + 1'b1;
          if (chomp == CLAST) close_mouth <= ~close_mouth;
        end else if (state != IDLE) begin
          close_mouth <= 1'b0;
          chomp <= '0;
        end
`ifdef PACMAN_TURN_BUFFER_EN
        pend_v <= ep_v && !(rev || turn);
        pend_dir <= ep_dir;
`else
        pend_v <= 1'b0;
`endif
      end else if (key_valid) begin
        pend_v <= 1'b1;
        pend_dir <= key_dir;
      end
    end
  end
endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// tb_pacman_motion_ctrl: scoreboard bench for pacman_motion_ctrl (works with or without PACMAN_TURN_BUFFER_EN).
module tb_pacman_motion_ctrl;
  logic clk = 0, resetN = 0, start_of_frame = 0, key_valid = 0, freeze = 0, respawn = 0;
  logic [1:0] key_dir = 0;
  logic [3:0] wall_ahead = 0;
  logic [10:0] top_left_x, top_left_y;
  logic [1:0] orientation;
  logic close_mouth, moving;
  int n_checks = 0, n_errors = 0;
  logic [10:0] ex = 304, ey = 224;
  logic [1:0] eo = 2'b11;
  logic emv = 0, ecm = 1;
  int fr = 0;
  logic [25:0] exp_q[$];
  string tag_q[$];
  pacman_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .start_of_frame(start_of_frame), .key_valid(key_valid),
    .key_dir(key_dir), .wall_ahead(wall_ahead), .freeze(freeze), .respawn(respawn),
    .top_left_x(top_left_x), .top_left_y(top_left_y), .orientation(orientation),
    .close_mouth(close_mouth), .moving(moving)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input string tag);
    exp_q.push_back({ex, ey, eo, emv, ecm});
    tag_q.push_back(tag);
  endtask
  task automatic pop_compare();
    logic [25:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".x"}, 32'(top_left_x), 32'(e[25:15]));
    check({t, ".y"}, 32'(top_left_y), 32'(e[14:4]));
    check({t, ".orient"}, 32'(orientation), 32'(e[3:2]));
    check({t, ".moving"}, 32'(moving), 32'(e[1]));
    check({t, ".mouth"}, 32'(close_mouth), 32'(e[0]));
  endtask
  task automatic step_exp();
    fr++;
    if (fr % 8 == 0) ecm = ~ecm;
    emv = 1;
    case (eo)
      2'b00: ey = ey - 1;
      2'b01: ey = ey + 1;
      2'b10: ex = (ex == 0) ? 11'd624 : ex - 1;
      default: ex = (ex == 624) ? 11'd0 : ex + 1;
    endcase
  endtask
  task automatic frame(input string tag, input logic kv, input logic [1:0] kd);
    push(tag);
    @(negedge clk);
    start_of_frame = 1;
    key_valid = kv;
    key_dir = kd;
    @(negedge clk);
    start_of_frame = 0;
    key_valid = 0;
    pop_compare();
  endtask
  task automatic key(input logic [1:0] d);
    @(negedge clk);
    key_valid = 1;
    key_dir = d;
    @(negedge clk);
    key_valid = 0;
  endtask
  task automatic reset_exp();
    ex = 304; ey = 224; eo = 2'b11; emv = 0; ecm = 1; fr = 0;
  endtask
  initial begin
    int toggles;
    logic last_cm;
    repeat (3) @(negedge clk);
    resetN = 1;
    push("reset");
    @(negedge clk);
    pop_compare();
    key(2'b11);
    eo = 2'b11;
    toggles = 0;
    last_cm = close_mouth;
    for (int i = 0; i < 20; i++) begin
      step_exp();
      frame("run_right", 0, 0);
      if (i < 16 && close_mouth != last_cm) toggles++;
      last_cm = close_mouth;
    end
    check("chomp_toggles_16", 32'(toggles), 32'd2);
    key(2'b00);
    for (int i = 0; i < 12; i++) begin
      step_exp();
      frame("pre_turn", 0, 0);
    end
    eo = 2'b00;
    step_exp();
`ifdef PACMAN_TURN_BUFFER_EN
    frame("aligned_turn", 0, 0);
`else
    frame("aligned_turn", 1, 2'b00);
`endif
    for (int i = 0; i < 15; i++) begin
      step_exp();
      frame("run_up", 0, 0);
    end
    wall_ahead = 4'b0001;
    emv = 0; ecm = 0; fr = 0;
    frame("wall_stop", 0, 0);
    frame("wall_hold", 0, 0);
    eo = 2'b01;
    step_exp();
    frame("unblock_down", 1, 2'b01);
    wall_ahead = 4'b0000;
    eo = 2'b00;
    step_exp();
    frame("reverse", 1, 2'b00);
    freeze = 1;
    for (int i = 0; i < 10; i++) frame("freeze", 1, 2'b01);
    freeze = 0;
    step_exp();
    frame("after_freeze", 0, 0);
    @(negedge clk);
    respawn = 1;
    @(negedge clk);
    respawn = 0;
    reset_exp();
    push("respawn");
    pop_compare();
    eo = 2'b10;
    step_exp();
    frame("start_left", 1, 2'b10);
    for (int i = 0; i < 304; i++) begin
      step_exp();
      frame("run_left", 0, 0);
    end
    check("wrap_left_x", 32'(top_left_x), 32'd624);
    eo = 2'b11;
    step_exp();
    frame("wrap_right", 1, 2'b11);
    check("wrap_right_x", 32'(top_left_x), 32'd0);
    step_exp();
    frame("after_wrap", 0, 0);
    #3 resetN = 0;
    #1;
    reset_exp();
    check("async_reset.x", 32'(top_left_x), 32'(ex));
    check("async_reset.moving", 32'(moving), 32'(emv));
    check("async_reset.orient", 32'(orientation), 32'(eo));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end
endmodule
